// File: rtl/ysyx_22050039_div_seq.sv
// ysyx_22050039_div_seq: multi-cycle radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W variants
module ysyx_22050039_div_seq #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            kill,
    output logic            stall,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);
    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic            word_q, word_d;
    logic [XLEN-1:0] src1_q, src1_d, src2_q, src2_d;
    logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, b_q, b_d, result_q, result_d;
    logic [6:0]      cnt_q, cnt_d;
    logic            qs_q, qs_d, rs_q, rs_d;
    logic            sgn, sa, sb, zero_b, ovf;
    logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b, min_neg, init_quo;
    logic [XLEN-1:0] st_rem, st_quo, st_b, rem_n, quo_n, spec_sel, fix_sel, pick, res_ext;
    logic [XLEN:0]   sh, diff;
    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction
    always_comb begin
        sgn      = ~op_q[0];
        a_ext    = word_q ? {{(XLEN-32){sgn & src1_q[31]}}, src1_q[31:0]} : src1_q;
        b_ext    = word_q ? {{(XLEN-32){sgn & src2_q[31]}}, src2_q[31:0]} : src2_q;
        sa       = sgn & a_ext[XLEN-1];
        sb       = sgn & b_ext[XLEN-1];
        abs_a    = sa ? -a_ext : a_ext;
        abs_b    = sb ? -b_ext : b_ext;
        min_neg  = word_q ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
        zero_b   = b_ext == '0;
        ovf      = sgn & (a_ext == min_neg) & (&b_ext);
        // W operands sit in the top half so the shift always pulls from the MSB
        init_quo = word_q ? {abs_a[31:0], {(XLEN-32){1'b0}}} : abs_a;
        st_rem   = (state_q == PREP) ? '0 : rem_q;
        st_quo   = (state_q == PREP) ? init_quo : quo_q;
        st_b     = (state_q == PREP) ? abs_b : b_q;
        sh       = {st_rem, st_quo[XLEN-1]};
        diff     = sh - {1'b0, st_b};
        rem_n    = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
        quo_n    = {st_quo[XLEN-2:0], ~diff[XLEN]};
        spec_sel = op_q[1] ? (zero_b ? a_ext : '0) : (zero_b ? '1 : a_ext);
        fix_sel  = op_q[1] ? (rs_q ? -rem_q : rem_q) : (qs_q ? -quo_q : quo_q);
        pick     = (state_q == PREP) ? spec_sel : fix_sel;
        res_ext  = word_q ? sext32(pick) : pick;
        state_d  = state_q;
        op_d     = op_q;
        word_d   = word_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        qs_d     = qs_q;
        rs_d     = rs_q;
        result_d = result_q;
        case (state_q)
            IDLE: if (in_valid && !kill) begin
                state_d = PREP;
                op_d    = op;
                word_d  = word;
                src1_d  = src1;
                src2_d  = src2;
            end
            PREP: if (zero_b || ovf) begin
                state_d  = DONE;
                result_d = res_ext;
            end else begin
                // the first shift-subtract step is folded into this cycle
                state_d = ITER;
                rem_d   = rem_n;
                quo_d   = quo_n;
                b_d     = abs_b;
                qs_d    = sa ^ sb;
                rs_d    = sa;
                cnt_d   = word_q ? 7'd31 : 7'(XLEN-1);
            end
            ITER: begin
                rem_d   = rem_n;
                quo_d   = quo_n;
                cnt_d   = cnt_q - 7'd1;
                state_d = (cnt_q == 7'd1) ? FIX : ITER;
            end
            FIX: begin
                state_d  = DONE;
                result_d = res_ext;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        if (kill && state_q != IDLE) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            word_q   <= 1'b0;
            src1_q   <= '0;
            src2_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            qs_q     <= 1'b0;
            rs_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            word_q   <= word_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            qs_q     <= qs_d;
            rs_q     <= rs_d;
            result_q <= result_d;
        end
    end
    assign in_ready  = state_q == IDLE;
    assign stall     = state_q != IDLE;
    assign out_valid = state_q == DONE;
    assign result    = result_q;
endmodule

// File: tb/tb_ysyx_22050039_div_seq.sv
// tb_ysyx_22050039_div_seq: directed and random divide/remainder requests checked against an arithmetic reference
module tb_ysyx_22050039_div_seq;
    logic        clk, rst, in_valid, in_ready, word, kill, stall, out_valid, out_ready;
    logic [1:0]  op;
    logic [63:0] src1, src2, result;
    int          n_vec, n_err;

    ysyx_22050039_div_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .word(word),
        .src1(src1), .src2(src2), .kill(kill), .stall(stall), .out_valid(out_valid),
        .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic w, input logic [63:0] x,
                                          input logic [63:0] y, output bit special);
        logic        sg;
        logic [63:0] a, b, q, r, res;
        sg = ~o[0];
        a = w ? (sg ? {{32{x[31]}}, x[31:0]} : {32'b0, x[31:0]}) : x;
        b = w ? (sg ? {{32{y[31]}}, y[31:0]} : {32'b0, y[31:0]}) : y;
        special = 1'b1;
        if (b == 64'd0) begin
            q = '1;
            r = a;
        end else if (sg && b == '1 && a == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) begin
            q = a;
            r = 64'd0;
        end else if (sg) begin
            special = 1'b0;
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            special = 1'b0;
            q = a / b;
            r = a % b;
        end
        res = o[1] ? r : q;
        return w ? {{32{res[31]}}, res[31:0]} : res;
    endfunction

    task automatic run(input logic [1:0] o, input logic w, input logic [63:0] x, input logic [63:0] y,
                       input logic [63:0] exp, input int lat, input int hold);
        int cyc;
        op = o; word = w; src1 = x; src2 = y; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        op = 2'($urandom); word = 1'($urandom); src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
        cyc = 1;
        chk("stall_busy", {63'b0, stall}, 64'd1);
        chk("in_ready_busy", {63'b0, in_ready}, 64'd0);
        while (!out_valid && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("latency", 64'(cyc), 64'(lat));
        chk("result", result, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_result", result, exp);
            chk("hold_valid", {63'b0, out_valid}, 64'd1);
            chk("hold_in_ready", {63'b0, in_ready}, 64'd0);
            chk("hold_stall", {63'b0, stall}, 64'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_valid", {63'b0, out_valid}, 64'd0);
        chk("post_stall", {63'b0, stall}, 64'd0);
        chk("post_result", result, exp);
    endtask

    initial begin
        bit          sp, seen;
        logic [1:0]  ro;
        logic        rw;
        logic [63:0] rx, ry, re;
        n_vec = 0; n_err = 0;
        clk = 0; rst = 1; in_valid = 0; op = 0; word = 0; src1 = 0; src2 = 0; kill = 0; out_ready = 0;
        repeat (2) tick();
        rst = 0;
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("rst_stall", {63'b0, stall}, 64'd0);
        chk("rst_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_result", result, 64'd0);

        run(2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, 0);
        run(2'd2, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34, 0);
        run(2'd1, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 34, 0);
        run(2'd1, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
        run(2'd3, 1'b0, 64'd5, 64'd0, 64'd5, 2, 1);
        run(2'd0, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 2, 0);
        run(2'd2, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2, 0);
        run(2'd0, 1'b0, 64'd100, 64'd7, 64'd14, 66, 5);
        run(2'd3, 1'b0, 64'd100, 64'd7, 64'd2, 66, 0);

        op = 2'd0; word = 1'b0; src1 = 64'd100; src2 = 64'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (11) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        chk("kill_stall", {63'b0, stall}, 64'd0);
        chk("kill_in_ready", {63'b0, in_ready}, 64'd1);
        chk("kill_valid", {63'b0, out_valid}, 64'd0);
        seen = 1'b0;
        repeat (70) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("kill_no_valid", {63'b0, seen}, 64'd0);
        run(2'd1, 1'b0, 64'd9, 64'd3, 64'd3, 66, 0);

        op = 2'd0; word = 1'b0; src1 = 64'd1000; src2 = 64'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_stall", {63'b0, stall}, 64'd0);
        chk("midrst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("midrst_valid", {63'b0, out_valid}, 64'd0);
        chk("midrst_result", result, 64'd0);

        op = 2'd1; word = 1'b0; src1 = 64'd50; src2 = 64'd5; in_valid = 1'b1; kill = 1'b1;
        tick();
        in_valid = 1'b0; kill = 1'b0;
        chk("killidle_stall", {63'b0, stall}, 64'd0);
        chk("killidle_in_ready", {63'b0, in_ready}, 64'd1);
        tick();
        chk("killidle_stall2", {63'b0, stall}, 64'd0);
        run(2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0);

        for (int k = 0; k < 30; k++) begin
            ro = 2'($urandom_range(0, 3));
            rw = 1'($urandom);
            rx = ($urandom_range(0, 5) == 0) ? (rw ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000)
                                              : {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: ry = 64'd0;
                1: ry = '1;
                2: ry = 64'($urandom_range(1, 20));
                3: ry = -64'($urandom_range(1, 20));
                default: ry = {$urandom, $urandom} >> $urandom_range(0, 40);
            endcase
            re = model(ro, rw, rx, ry, sp);
            run(ro, rw, rx, ry, re, sp ? 2 : (rw ? 34 : 66), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
